life_data_high: RTL and testbench
=================================

# life_data_high

Upper segment of the Life board's circular shift register and the generation engine. Holds the top HIGH_BITS cells, rotates them one position per clock in lock-step with life_data_low, and feeds life_data_low through data_high[X*Y-HIGH_BITS]. Computes each cell's next-generation value from its 8 neighbours as the cell passes the evaluation point. Sequences generations: free-running, single-step, or frozen.

## Interface
- X, 8, board width; power of two
- Y, 8, board height; power of two
- HIGH_BITS, X+3, cells held in this block; must be ≥ X+3
- LOG2X, 3, log2(X)
- LOG2Y, 3, log2(Y)
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clk
- data_low_lsb  in  1  life_data_low bit 0; the cell wrapping to the top of the ring
- run  in  1  level; start a new generation at every boundary
- step  in  1  one-cycle pulse; request exactly one generation
- data_high  out  [X*Y-1:X*Y-HIGH_BITS]  upper ring segment; bit X*Y-HIGH_BITS feeds life_data_low
- cell_index  out  LOG2X+LOG2Y  original board index {row,col} of the cell now at the evaluation point
- busy  out  1  generation in progress
- gen_done  out  1  one-cycle pulse after the last cell of a generation
- gen_count  out  16  completed generations; wraps at 65535
- population  out  LOG2X+LOG2Y+1  live cells produced by the last completed generation

## Operation
- Evaluation point E = data_high[X*Y-HIGH_BITS+1], holding the old value.
- Every cycle: data_high <= {data_low_lsb, data_high[X*Y-1:X*Y-HIGH_BITS+2], new_E}.
- Ahead neighbours are still old and are taken from data_high: E+1, E+X-1, E+X, E+X+1.
- Behind neighbours have already been rewritten, so their old values come from history: a hist shift register of X+1 bits, shifted with old E every cycle.
  - hist[0] = E-1, hist[X-2] = E-X+1, hist[X-1] = E-X, hist[X] = E-X-1.
- Board edges are dead, with no torus. Masks derived from cell_index:
  - col 0 masks the -1 neighbours; col X-1 masks the +1 neighbours.
  - row 0 masks the -X neighbours; row Y-1 masks the +X neighbours.
- Rule while busy: new_E = (n==3) | (E & n==2), where n is the masked count in 0..8.
- While not busy: new_E = E, i.e. pure rotation.
- cell_index resets to X*Y-HIGH_BITS+1 and increments mod X*Y every cycle.
- FSM states: IDLE, ACTIVE.
  - IDLE -> ACTIVE on the cycle cell_index becomes 0, if run or step_pending.
  - ACTIVE -> IDLE after cell_index X*Y-1 is evaluated, unless run or step_pending.
  - Otherwise ACTIVE -> ACTIVE with no gap cycle.
- step_pending:
  - Set by step in any state.
  - Cleared when the generation it launches starts.
  - A step arriving while that generation is ACTIVE re-arms it for the next generation.
  - Multiple steps before a start count once.
- population accumulates new_E over the generation. It is updated together with gen_done and includes the last cell.
- An external flip in life_data_low during ACTIVE is accepted as-is. Its effect is undefined only for the current generation.

## Timing
- Reset values:
  - data_high = 0, hist = 0.
  - cell_index = X*Y-HIGH_BITS+1.
  - busy = 0, gen_done = 0, gen_count = 0, population = 0.
  - step_pending = 0, state IDLE.
- Reset mid-generation abandons it: no gen_done and no count increment.
- new_E appears at data_high[X*Y-HIGH_BITS] one cycle after the old cell sits at E. life_data_low captures it on the following edge.
- One generation lasts exactly X*Y cycles. The step-to-start wait is 1..X*Y cycles.
- busy is high for cycles where cell_index = 0..X*Y-1 of an active generation.
- gen_done, gen_count and population update on the edge after cell X*Y-1 is evaluated.
- The ring rotates every cycle regardless of state. life_data_low has no enable, so this block has none either.

## Structure
- Shared life_pkg holds the FSM state encoding, the X*Y ring length, and the neighbour-offset constants.
- The constants are shared with the display/cursor logic, which consumes cell_index.
- Sub-module life_rule (combinational): 8 neighbour bits, 8 mask bits and old E in; new_E out.
- life_data_high instantiates life_rule once; history, counters and FSM stay in the top.

## Test plan
All scenarios use X=Y=8 with a reference model of the full 64-bit ring built from life_data_high + life_data_low.
- run=0, seed cells {2,2},{5,7}; 128 cycles -> ring identical every 64 cycles; busy=0; gen_count=0.
- Blinker at row 3, cols 2..4; step once -> after gen_done: vertical at col 3, rows 2..4; population=3; gen_count=1. Second step -> horizontal again.
- 2x2 block at {0,0}; run=1 for 3 generations -> pattern unchanged; population=4 each gen_done; gen_count=3; no busy gaps.
- Single live cell at {7,7}; step -> board empty, population=0. Glider driven into a corner dies or becomes a block per the dead-edge model.
- step pulsed twice in IDLE, then again mid-generation -> exactly two generations run, back-to-back.
- reset pulled low at cell_index 30 of an ACTIVE generation -> next cycle all outputs are at their reset values; gen_done is never pulsed.

Source files
------------

// File: rtl/life_pkg.sv
// Shared Life board constants: FSM encoding, default ring geometry and neighbour slots.
// Also used by the display/cursor logic that decodes cell_index.
package life_pkg;

  localparam int LIFE_X     = 8;
  localparam int LIFE_Y     = 8;
  localparam int LIFE_CELLS = LIFE_X * LIFE_Y;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } life_state_e;

  // Slot order of the 8-bit neighbour/mask vectors handed to life_rule
  localparam int NB_NW = 0;  // E-X-1
  localparam int NB_N  = 1;  // E-X
  localparam int NB_NE = 2;  // E-X+1
  localparam int NB_W  = 3;  // E-1
  localparam int NB_E  = 4;  // E+1
  localparam int NB_SW = 5;  // E+X-1
  localparam int NB_S  = 6;  // E+X
  localparam int NB_SE = 7;  // E+X+1

  localparam logic [7:0] NB_ROW_UP    = 8'b0000_0111;
  localparam logic [7:0] NB_ROW_DOWN  = 8'b1110_0000;
  localparam logic [7:0] NB_COL_LEFT  = 8'b0010_1001;
  localparam logic [7:0] NB_COL_RIGHT = 8'b1001_0100;

  // Board edges are dead: a set bit in the result means the neighbour exists.
  function automatic logic [7:0] nb_mask(input logic top, input logic bottom,
                                         input logic left, input logic right);
    logic [7:0] m;
    m = 8'hFF;
    if (top)    m = m & ~NB_ROW_UP;
    if (bottom) m = m & ~NB_ROW_DOWN;
    if (left)   m = m & ~NB_COL_LEFT;
    if (right)  m = m & ~NB_COL_RIGHT;
    return m;
  endfunction

endpackage

// File: rtl/life_rule.sv
// Conway rule for one cell: counts the unmasked live neighbours and applies B3/S23.
// Purely combinational; no flow control.
module life_rule (
  input  logic [7:0] nb,
  input  logic [7:0] mask,
  input  logic       cell_old,
  output logic       cell_new
);

  logic [3:0] n;

  always_comb begin
    n = '0;
    for (int i = 0; i < 8; i++) begin
      if (nb[i] & mask[i]) n = n + 4'd1;
    end
    cell_new = (n == 4'd3) | (cell_old & (n == 4'd2));
  end

endmodule

// File: rtl/life_data_high.sv
// Upper ring segment plus generation engine; new cell value leaves one cycle after reaching E.
// No stall: the ring rotates every cycle, in lock-step with life_data_low.
module life_data_high
  import life_pkg::*;
#(
  parameter int X         = 8,
  parameter int Y         = 8,
  parameter int HIGH_BITS = X + 3,
  parameter int LOG2X     = 3,
  parameter int LOG2Y     = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          data_low_lsb,
  input  logic                          run,
  input  logic                          step,
  output logic [X*Y-1:X*Y-HIGH_BITS]    data_high,
  output logic [LOG2X+LOG2Y-1:0]        cell_index,
  output logic                          busy,
  output logic                          gen_done,
  output logic [15:0]                   gen_count,
  output logic [LOG2X+LOG2Y:0]          population
);

  localparam int N  = X * Y;
  localparam int EP = N - HIGH_BITS + 1;
  localparam int CW = LOG2X + LOG2Y;
  localparam logic [CW-1:0] CI_RST  = CW'(EP);
  localparam logic [CW-1:0] CI_LAST = CW'(N - 1);

  logic [N-1:N-HIGH_BITS] data_high_q, data_high_d;
  logic [X:0]             hist_q, hist_d;
  logic [CW-1:0]          cell_index_q, cell_index_d;
  life_state_e            state_q, state_d;
  logic                   step_pending_q, step_pending_d;
  logic                   gen_done_q, gen_done_d;
  logic [15:0]            gen_count_q, gen_count_d;
  logic [CW:0]            population_q, population_d;
  logic [CW:0]            pop_acc_q, pop_acc_d;

  logic                   e_old, rule_out, new_e;
  logic                   busy_w, last, launch;
  logic [7:0]             nb, mask;
  logic [LOG2Y-1:0]       row;
  logic [LOG2X-1:0]       col;
  logic [CW:0]            pop_inc;

  life_rule u_rule (
    .nb       (nb),
    .mask     (mask),
    .cell_old (e_old),
    .cell_new (rule_out)
  );

  always_comb begin
    e_old = data_high_q[EP];
    row   = cell_index_q[CW-1:LOG2X];
    col   = cell_index_q[LOG2X-1:0];

    // Cells behind E were already rewritten; their old values live in hist.
    nb        = '0;
    nb[NB_NW] = hist_q[X];
    nb[NB_N]  = hist_q[X-1];
    nb[NB_NE] = hist_q[X-2];
    nb[NB_W]  = hist_q[0];
    nb[NB_E]  = data_high_q[EP+1];
    nb[NB_SW] = data_high_q[EP+X-1];
    nb[NB_S]  = data_high_q[EP+X];
    nb[NB_SE] = data_high_q[EP+X+1];
    mask      = nb_mask(row == '0, row == {LOG2Y{1'b1}},
                        col == '0, col == {LOG2X{1'b1}});

    busy_w = (state_q == ST_ACTIVE);
    last   = (cell_index_q == CI_LAST);
    launch = last & (run | step | step_pending_q);
    new_e  = busy_w ? rule_out : e_old;

    data_high_d  = {data_low_lsb, data_high_q[N-1:EP+1], new_e};
    hist_d       = {hist_q[X-1:0], e_old};
    cell_index_d = cell_index_q + CW'(1);

    // Generation boundaries fall only where cell_index wraps to 0.
    state_d = state_q;
    if (last) state_d = launch ? ST_ACTIVE : ST_IDLE;

    step_pending_d = (step_pending_q | step) & ~launch;

    pop_inc      = {{CW{1'b0}}, busy_w & new_e};
    pop_acc_d    = last ? '0 : pop_acc_q + pop_inc;
    gen_done_d   = busy_w & last;
    gen_count_d  = gen_count_q;
    population_d = population_q;
    if (busy_w & last) begin
      gen_count_d  = gen_count_q + 16'd1;
      population_d = pop_acc_q + pop_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_high_q    <= '0;
      hist_q         <= '0;
      cell_index_q   <= CI_RST;
      state_q        <= ST_IDLE;
      step_pending_q <= 1'b0;
      gen_done_q     <= 1'b0;
      gen_count_q    <= '0;
      population_q   <= '0;
      pop_acc_q      <= '0;
    end else begin
      data_high_q    <= data_high_d;
      hist_q         <= hist_d;
      cell_index_q   <= cell_index_d;
      state_q        <= state_d;
      step_pending_q <= step_pending_d;
      gen_done_q     <= gen_done_d;
      gen_count_q    <= gen_count_d;
      population_q   <= population_d;
      pop_acc_q      <= pop_acc_d;
    end
  end

  assign data_high  = data_high_q;
  assign cell_index = cell_index_q;
  assign busy       = (state_q == ST_ACTIVE);
  assign gen_done   = gen_done_q;
  assign gen_count  = gen_count_q;
  assign population = population_q;

endmodule

// File: tb/tb_life_data_high.sv
// Bench for life_data_high on an 8x8 board; models life_data_low and checks whole-board generations.
// Expected generations are queued at stimulus time and popped by a monitor on gen_done.
module tb_life_data_high;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic        data_low_lsb;
  logic [63:53] data_high;
  logic [5:0]  cell_index;
  logic        busy, gen_done;
  logic [15:0] gen_count;
  logic [6:0]  population;

  logic [52:0] low_q;
  logic [5:0]  k_q;
  logic        seed_req = 1'b0;
  logic [52:0] seed_vec = '0;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [63:0] board;
    logic [6:0]  pop;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] model_board = '0;
  logic [15:0] model_cnt = '0;

  life_data_high #(.X(8), .Y(8), .HIGH_BITS(11), .LOG2X(3), .LOG2Y(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_low_lsb (data_low_lsb),
    .run          (run),
    .step         (step),
    .data_high    (data_high),
    .cell_index   (cell_index),
    .busy         (busy),
    .gen_done     (gen_done),
    .gen_count    (gen_count),
    .population   (population)
  );

  always #5 clk = ~clk;

  // Lower ring segment; seed_req overwrites it with a board image for the next cycle.
  assign data_low_lsb = low_q[0];
  always @(posedge clk) begin
    if (!reset) begin
      low_q <= '0;
      k_q   <= '0;
    end else begin
      low_q <= seed_req ? seed_vec : {data_high[53], low_q[52:1]};
      k_q   <= k_q + 6'd1;
    end
  end

  function automatic logic [63:0] cellbit(input int r, input int c);
    return 64'(1) << (r * 8 + c);
  endfunction

  // After k rotations, ring position p holds board cell (p + k) mod 64.
  function automatic logic [63:0] cur_board();
    logic [63:0] ring, b;
    ring = {data_high, low_q};
    for (int c = 0; c < 64; c++) b[c] = ring[(c - int'(k_q) + 64) % 64];
    return b;
  endfunction

  function automatic logic [63:0] life_next(input logic [63:0] b);
    logic [63:0] nb;
    int cnt;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8)
              if (b[(r + dr) * 8 + c + dc]) cnt++;
          end
        end
        nb[r * 8 + c] = (cnt == 3) || (b[r * 8 + c] && cnt == 2);
      end
    end
    return nb;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    check("cell_index", 64'(cell_index), 64'((54 + int'(k_q)) % 64));
    if (gen_done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL gen_done: pulse with no generation expected, gen_count=%0d", gen_count);
      end else begin
        e = sb_q.pop_front();
        check("gen_board", cur_board(), e.board);
        check("gen_population", 64'(population), 64'(e.pop));
        check("gen_count", 64'(gen_count), 64'(e.cnt));
      end
    end
  end

  task automatic seed(input logic [63:0] b);
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      for (int p = 0; p < 53; p++) seed_vec[p] = b[(p + int'(k_q) + 1) % 64];
      seed_req = 1'b1;
      @(negedge clk);
      seed_req = 1'b0;
      repeat (30) @(negedge clk);
    end
    model_board = b;
  endtask

  task automatic push_gens(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      model_board = life_next(model_board);
      model_cnt   = model_cnt + 16'd1;
      e.board = model_board;
      e.pop   = 7'($countones(model_board));
      e.cnt   = model_cnt;
      sb_q.push_back(e);
    end
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  // Waits for the launch, then expects n_gens*64 contiguous busy cycles.
  task automatic run_window(input int n_gens, input bit use_run, input int step_at,
                            input int pre, input string tag);
    int waited;
    bit gap;
    waited = 0;
    gap = 1'b0;
    while (busy !== 1'b1 && waited < 140) begin
      @(negedge clk);
      waited++;
    end
    n_tests++;
    if (busy !== 1'b1 || waited + pre > 64 || waited + pre < 1) begin
      n_fail++;
      $display("FAIL %s_start: busy=%b after %0d cycles, required within 1..64", tag, busy, waited + pre);
      run = 1'b0;
      return;
    end
    for (int i = 0; i < n_gens * 64; i++) begin
      if (busy !== 1'b1) gap = 1'b1;
      if (use_run && i == n_gens * 64 - 60) run = 1'b0;
      step = (i == step_at);
      @(negedge clk);
    end
    step = 1'b0;
    check({tag, "_no_gap"}, 64'(gap), 64'(0));
    check({tag, "_busy_end"}, 64'(busy), 64'(0));
    check({tag, "_gen_done"}, 64'(gen_done), 64'(1));
  endtask

  initial begin
    logic [63:0] b, r0;
    bit busy_seen;
    int n;

    repeat (3) @(negedge clk);
    check("rst_data_high", 64'(data_high), 64'(0));
    check("rst_cell_index", 64'(cell_index), 64'(54));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_gen_done", 64'(gen_done), 64'(0));
    check("rst_gen_count", 64'(gen_count), 64'(0));
    check("rst_population", 64'(population), 64'(0));
    reset = 1'b1;
    @(negedge clk);

    // Idle rotation: ring repeats every 64 cycles, nothing evolves
    b = cellbit(2, 2) | cellbit(5, 7);
    seed(b);
    check("idle_seed_board", cur_board(), b);
    r0 = {data_high, low_q};
    busy_seen = 1'b0;
    repeat (64) begin @(negedge clk); busy_seen |= busy; end
    check("idle_ring_64", {data_high, low_q}, r0);
    repeat (64) begin @(negedge clk); busy_seen |= busy; end
    check("idle_ring_128", {data_high, low_q}, r0);
    check("idle_busy", 64'(busy_seen), 64'(0));
    check("idle_gen_count", 64'(gen_count), 64'(0));

    // Blinker, two single steps
    seed(cellbit(3, 2) | cellbit(3, 3) | cellbit(3, 4));
    push_gens(1);
    pulse_step();
    run_window(1, 1'b0, -1, 1, "blink1");
    check("blink1_vertical", cur_board(), cellbit(2, 3) | cellbit(3, 3) | cellbit(4, 3));
    check("blink1_pop", 64'(population), 64'(3));
    push_gens(1);
    pulse_step();
    run_window(1, 1'b0, -1, 1, "blink2");
    check("blink2_horizontal", cur_board(), cellbit(3, 2) | cellbit(3, 3) | cellbit(3, 4));

    // Still-life block in the corner, three free-running generations
    seed(cellbit(0, 0) | cellbit(0, 1) | cellbit(1, 0) | cellbit(1, 1));
    push_gens(3);
    run = 1'b1;
    run_window(3, 1'b1, -1, 0, "block");
    check("block_pop", 64'(population), 64'(4));
    check("block_count", 64'(gen_count), 64'(5));

    // Lone corner cell dies
    seed(cellbit(7, 7));
    push_gens(1);
    pulse_step();
    run_window(1, 1'b0, -1, 1, "lone");
    check("lone_board", cur_board(), 64'(0));
    check("lone_pop", 64'(population), 64'(0));

    // Glider heading into the bottom-right corner
    seed(cellbit(3, 5) | cellbit(4, 6) | cellbit(5, 4) | cellbit(5, 5) | cellbit(5, 6));
    push_gens(10);
    run = 1'b1;
    run_window(10, 1'b1, -1, 0, "glider");

    // Two steps in IDLE count once; a third mid-generation re-arms for one more
    b = {$urandom, $urandom};
    seed(b);
    for (int i = 0; i < 64 && (54 + int'(k_q)) % 64 != 10; i++) @(negedge clk);
    push_gens(2);
    pulse_step();
    pulse_step();
    @(negedge clk);
    run_window(2, 1'b0, 30, 3, "dstep");
    busy_seen = 1'b0;
    repeat (70) begin @(negedge clk); busy_seen |= busy; end
    check("dstep_no_third", 64'(busy_seen), 64'(0));

    // Random boards, random launch phase, step or run
    for (int it = 0; it < 4; it++) begin
      b = {$urandom, $urandom};
      seed(b);
      repeat ($urandom_range(0, 63)) @(negedge clk);
      n = $urandom_range(1, 3);
      push_gens(n);
      if (n == 1) begin
        pulse_step();
        run_window(1, 1'b0, -1, 1, "rand_step");
      end else begin
        run = 1'b1;
        run_window(n, 1'b1, -1, 0, "rand_run");
      end
    end

    // Reset at cell 30 of an active generation abandons it
    seed({$urandom, $urandom});
    pulse_step();
    for (int i = 0; i < 140 && busy !== 1'b1; i++) @(negedge clk);
    check("rstmid_busy", 64'(busy), 64'(1));
    repeat (30) @(negedge clk);
    check("rstmid_at30", 64'(cell_index), 64'(30));
    reset = 1'b0;
    @(negedge clk);
    check("rstmid_data_high", 64'(data_high), 64'(0));
    check("rstmid_cell_index", 64'(cell_index), 64'(54));
    check("rstmid_busy0", 64'(busy), 64'(0));
    check("rstmid_gen_done", 64'(gen_done), 64'(0));
    check("rstmid_gen_count", 64'(gen_count), 64'(0));
    check("rstmid_population", 64'(population), 64'(0));
    model_board = '0;
    model_cnt = '0;
    reset = 1'b1;
    busy_seen = 1'b0;
    repeat (140) begin @(negedge clk); busy_seen |= busy; end
    check("rstmid_stays_idle", 64'(busy_seen), 64'(0));

    check("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
